mem_arbiter: RTL

- Shares the single-ported, multi-cycle `ram` block between the instruction-fetch unit (IFU) and the load/store unit (LSU) of the miniRV core.
- Accepts one request at a time from either requester and issues it to the RAM as a one-cycle `reqValid` pulse with stable operands.
- Waits for the RAM's `respValid` and returns the read data to the requester that issued the request.
- Provides round-robin or fixed-priority arbitration and a response-timeout safety net.

---
 rtl/mem_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported multi-cycle RAM between the IFU and the LSU,
// one outstanding request at a time, with round-robin or LSU-priority arbitration and a response timeout.
module mem_arbiter #(
    parameter int XLEN         = 32,
    parameter int LSU_PRIORITY = 0,
    parameter int TIMEOUT      = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ifu_req_valid,
    output logic            ifu_req_ready,
    input  logic [XLEN-1:0] ifu_addr,
    output logic            ifu_resp_valid,
    output logic [XLEN-1:0] ifu_rdata,
    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic            lsu_wen,
    input  logic [XLEN-1:0] lsu_addr,
    input  logic [XLEN-1:0] lsu_wdata,
    input  logic [3:0]      lsu_wbmask,
    output logic            lsu_resp_valid,
    output logic [XLEN-1:0] lsu_rdata,
    output logic            err,
    output logic            mem_reqValid,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wbmask,
    input  logic            mem_respValid,
    input  logic [XLEN-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    localparam int CW = $clog2(TIMEOUT);
    state_t          state_q, state_d;
    logic            last_lsu_q, last_lsu_d, grant_lsu_q, grant_lsu_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            req_valid_q, req_valid_d, wen_q, wen_d, err_q, err_d;
    logic            ifu_resp_q, ifu_resp_d, lsu_resp_q, lsu_resp_d;
    logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [XLEN-1:0] ifu_rdata_q, ifu_rdata_d, lsu_rdata_q, lsu_rdata_d;
    logic [3:0]      wbmask_q, wbmask_d;
    logic            grant, pick_lsu, timed_out, done;
    logic [XLEN-1:0] cap;
    // On a tie the LSU wins under fixed priority, otherwise whoever was not granted last
    assign pick_lsu      = lsu_req_valid && (!ifu_req_valid || LSU_PRIORITY != 0 || !last_lsu_q);
    assign grant         = state_q == IDLE && (ifu_req_valid || lsu_req_valid);
    assign ifu_req_ready = grant && !pick_lsu;
    assign lsu_req_ready = grant && pick_lsu;
    assign timed_out     = cnt_q == CW'(TIMEOUT - 1);
    assign done          = state_q == WAIT && (mem_respValid || timed_out);
    assign cap           = mem_respValid && !wen_q ? mem_rdata : '0;
    always_comb begin
        state_d     = grant ? REQ : state_q == REQ ? WAIT : done ? RESP : state_q == RESP ? IDLE : state_q;
        last_lsu_d  = grant ? pick_lsu : last_lsu_q;
        grant_lsu_d = grant ? pick_lsu : grant_lsu_q;
        req_valid_d = grant;
        wen_d       = grant ? pick_lsu && lsu_wen : wen_q;
        addr_d      = grant ? (pick_lsu ? lsu_addr : ifu_addr) : addr_q;
        wdata_d     = grant ? (pick_lsu ? lsu_wdata : '0) : wdata_q;
        wbmask_d    = grant ? (pick_lsu ? lsu_wbmask : '0) : wbmask_q;
        cnt_d       = state_q == WAIT ? cnt_q + 1'b1 : '0;
        ifu_resp_d  = done && !grant_lsu_q;
        lsu_resp_d  = done && grant_lsu_q;
        err_d       = done && !mem_respValid;
        ifu_rdata_d = ifu_resp_d ? cap : ifu_rdata_q;
        lsu_rdata_d = lsu_resp_d ? cap : lsu_rdata_q;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            last_lsu_q  <= 1'b1;
            grant_lsu_q <= 1'b0;
            cnt_q       <= '0;
            req_valid_q <= 1'b0;
            wen_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wbmask_q    <= '0;
            ifu_resp_q  <= 1'b0;
            lsu_resp_q  <= 1'b0;
            err_q       <= 1'b0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_lsu_q  <= last_lsu_d;
            grant_lsu_q <= grant_lsu_d;
            cnt_q       <= cnt_d;
            req_valid_q <= req_valid_d;
            wen_q       <= wen_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wbmask_q    <= wbmask_d;
            ifu_resp_q  <= ifu_resp_d;
            lsu_resp_q  <= lsu_resp_d;
            err_q       <= err_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
        end
    end
    assign mem_reqValid   = req_valid_q;
    assign mem_wen        = wen_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign mem_wbmask     = wbmask_q;
    assign ifu_resp_valid = ifu_resp_q;
    assign lsu_resp_valid = lsu_resp_q;
    assign ifu_rdata      = ifu_rdata_q;
    assign lsu_rdata      = lsu_rdata_q;
    assign err            = err_q;
endmodule
